// File: rtl/pwm_cfg_sched.sv
// pwm_cfg_sched: sequencer and configuration scheduler for the PWM generator.
//
// This block owns the PWM time base: the prescaler, the free-running count_val
// and pwm_en. Configuration values are double-buffered. A write from the
// register file goes into a shadow register first. The shadow becomes active
// only at a safe point: immediately when the time base is idle, otherwise on a
// period wrap. Because of this, pwm_gen never sees a torn or glitched period.
//
// Build option:
//   PWM_ONESHOT_EN - adds the 'oneshot' input. With oneshot=1 the time base
//                    stops after its first period. It stays idle until run
//                    goes low and then high again.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   level, 1 = time base running
//   oneshot               (PWM_ONESHOT_EN only) stop after one period
//   cfg_valid/cfg_ready   config handshake; the transfer happens when both are 1
//   cfg_period/functions/compare1/compare2/prescale
//                         offered configuration
//   cfg_err               1-cycle pulse: functions==11 was offered and rejected
//   pwm_en                time base running
//   period/functions/compare1/compare2
//                         active configuration, to pwm_gen
//   count_val             counter, to pwm_gen
//   period_end            1-cycle pulse in the cycle after the wrap (count_val==0)
//   commit_done           1-cycle pulse when shadow values become active
module pwm_cfg_sched #(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
`ifdef PWM_ONESHOT_EN
  input  logic               oneshot,
`endif
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [1:0]         cfg_functions,
  input  logic [CNT_W-1:0]   cfg_compare1,
  input  logic [CNT_W-1:0]   cfg_compare2,
  input  logic [PRESC_W-1:0] cfg_prescale,
  output logic               cfg_err,
  output logic               pwm_en,
  output logic [CNT_W-1:0]   period,
  output logic [1:0]         functions,
  output logic [CNT_W-1:0]   compare1,
  output logic [CNT_W-1:0]   compare2,
  output logic [CNT_W-1:0]   count_val,
  output logic               period_end,
  output logic               commit_done
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   sh_period, sh_cmp1, sh_cmp2;
  logic [1:0]         sh_func;
  logic [PRESC_W-1:0] sh_presc, act_presc, presc;
  logic               shadow_full;
  logic               rdy_rel;     // reopen cfg_ready one cycle after a wrap commit
  logic               armed;
  logic               acc, rej, tick, wrap, stop, commit_now, pend_keep;

  assign acc  = cfg_valid && cfg_ready && (cfg_functions != 2'b11);
  assign rej  = cfg_valid && cfg_ready && (cfg_functions == 2'b11);
  assign tick = (presc == act_presc) && (state != IDLE);
  // Periods 0 and 1 have no counting room, so every tick wraps.
  assign wrap = tick && ((period <= CNT_W'(1)) || (count_val == period - CNT_W'(1)));

`ifdef PWM_ONESHOT_EN
  assign stop = oneshot && period_end && (state != IDLE);
`else
  assign stop  = 1'b0;
  assign armed = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    if (!run || stop) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (armed) state_nx = acc ? PEND : RUN;
        RUN:     if (acc)   state_nx = PEND;
        PEND:    if (wrap)  state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // The shadow commits in three cases: at any time while idle, on the
  // transition into idle, and on a wrap while a commit is pending.
  assign commit_now = shadow_full &&
                      ((state == IDLE) || (state_nx == IDLE) || ((state == PEND) && wrap));
  // A commit on a wrap while still running reopens cfg_ready one cycle late.
  assign pend_keep  = (state == PEND) && run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
      pwm_en      <= 1'b0;
      period      <= '0;
      functions   <= '0;
      compare1    <= '0;
      compare2    <= '0;
      act_presc   <= '0;
      sh_period   <= '0;
      sh_func     <= '0;
      sh_cmp1     <= '0;
      sh_cmp2     <= '0;
      sh_presc    <= '0;
      shadow_full <= 1'b0;
      rdy_rel     <= 1'b0;
      presc       <= '0;
      count_val   <= '0;
      period_end  <= 1'b0;
      commit_done <= 1'b0;
`ifdef PWM_ONESHOT_EN
      armed       <= 1'b1;
`endif
    end else begin
      state       <= state_nx;
      pwm_en      <= (state_nx != IDLE);
      cfg_err     <= rej;
      commit_done <= commit_now;
      rdy_rel     <= commit_now && pend_keep;

`ifdef PWM_ONESHOT_EN
      if (!run)      armed <= 1'b1;
      else if (stop) armed <= 1'b0;
`endif

      // Shadow capture and the handshake.
      if (acc) begin
        sh_period   <= cfg_period;
        sh_func     <= cfg_functions;
        sh_cmp1     <= cfg_compare1;
        sh_cmp2     <= cfg_compare2;
        sh_presc    <= cfg_prescale;
        shadow_full <= 1'b1;
        cfg_ready   <= 1'b0;
      end else if (commit_now) begin
        shadow_full <= 1'b0;
        if (!pend_keep) cfg_ready <= 1'b1;
      end else if (rdy_rel) begin
        cfg_ready <= 1'b1;
      end

      if (commit_now) begin
        period    <= sh_period;
        functions <= sh_func;
        compare1  <= sh_cmp1;
        compare2  <= sh_cmp2;
        act_presc <= sh_presc;
      end

      // Time base. On entry to or exit from IDLE, everything restarts from 0.
      if ((state_nx == IDLE) || (state == IDLE)) begin
        presc      <= '0;
        count_val  <= '0;
        period_end <= 1'b0;
      end else begin
        period_end <= wrap;
        if (tick) begin
          presc     <= '0;
          count_val <= wrap ? '0 : count_val + CNT_W'(1);
        end else begin
          presc <= presc + PRESC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_cfg_sched.sv
module tb_pwm_cfg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
`ifdef PWM_ONESHOT_EN
  logic        oneshot;
`endif
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [1:0]  cfg_functions;
  logic [15:0] cfg_compare1;
  logic [15:0] cfg_compare2;
  logic [7:0]  cfg_prescale;
  logic        cfg_err;
  logic        pwm_en;
  logic [15:0] period;
  logic [1:0]  functions;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [15:0] count_val;
  logic        period_end;
  logic        commit_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_cfg_sched #(.CNT_W(16), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef PWM_ONESHOT_EN
    .oneshot(oneshot),
`endif
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_period(cfg_period),
    .cfg_functions(cfg_functions), .cfg_compare1(cfg_compare1), .cfg_compare2(cfg_compare2),
    .cfg_prescale(cfg_prescale), .cfg_err(cfg_err), .pwm_en(pwm_en), .period(period),
    .functions(functions), .compare1(compare1), .compare2(compare2), .count_val(count_val),
    .period_end(period_end), .commit_done(commit_done)
  );

  typedef struct {
    logic        run, vld;
    logic [15:0] per;
    logic [1:0]  fn;
    logic [15:0] c1;
    logic [7:0]  ps;
    logic        e_rdy, e_err, e_en;
    logic [15:0] e_per, e_cnt;
    logic        e_pe, e_cd;
  } vec_t;

  vec_t tv[21];

  function automatic vec_t mk(logic r, logic v, logic [15:0] p, logic [1:0] f, logic [15:0] c,
                              logic [7:0] s, logic rdy, logic err, logic en, logic [15:0] ep,
                              logic [15:0] ec, logic pe, logic cd);
    vec_t t;
    t.run = r; t.vld = v; t.per = p; t.fn = f; t.c1 = c; t.ps = s;
    t.e_rdy = rdy; t.e_err = err; t.e_en = en; t.e_per = ep; t.e_cnt = ec;
    t.e_pe = pe; t.e_cd = cd;
    return t;
  endfunction

  function automatic logic [36:0] pk(logic rdy, logic err, logic en, logic [15:0] p,
                                     logic [15:0] c, logic pe, logic cd);
    return {rdy, err, en, p, c, pe, cd};
  endfunction

  function automatic logic [36:0] obs();
    return pk(cfg_ready, cfg_err, pwm_en, period, count_val, period_end, commit_done);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] p, input logic [1:0] f,
                       input logic [15:0] c, input logic [7:0] s);
    run = r; cfg_valid = v; cfg_period = p; cfg_functions = f;
    cfg_compare1 = c; cfg_compare2 = c + 16'd1; cfg_prescale = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Format: run vld per fn c1 ps | rdy err en per cnt pe cd (values after the edge)
    tv[0]  = mk(0, 1, 10, 0, 3, 0,  0, 0, 0,  0, 0, 0, 0); // accept while idle
    tv[1]  = mk(0, 0,  0, 0, 0, 0,  1, 0, 0, 10, 0, 0, 1); // commit 1 cycle later
    tv[2]  = mk(0, 0,  0, 0, 0, 0,  1, 0, 0, 10, 0, 0, 0);
    tv[3]  = mk(0, 1,  4, 0, 3, 0,  0, 0, 0, 10, 0, 0, 0);
    tv[4]  = mk(0, 0,  0, 0, 0, 0,  1, 0, 0,  4, 0, 0, 1);
    tv[5]  = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  4, 0, 0, 0); // start
    tv[6]  = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  4, 1, 0, 0);
    tv[7]  = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  4, 2, 0, 0);
    tv[8]  = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  4, 3, 0, 0);
    tv[9]  = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  4, 0, 1, 0); // wrap
    tv[10] = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  4, 1, 0, 0);
    tv[11] = mk(1, 1,  6, 1, 2, 0,  0, 0, 1,  4, 2, 0, 0); // write period 6 at cnt 1
    tv[12] = mk(1, 0,  0, 0, 0, 0,  0, 0, 1,  4, 3, 0, 0);
    tv[13] = mk(1, 0,  0, 0, 0, 0,  0, 0, 1,  6, 0, 1, 1); // commit on the wrap
    tv[14] = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  6, 1, 0, 0);
    tv[15] = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  6, 2, 0, 0);
    tv[16] = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  6, 3, 0, 0);
    tv[17] = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  6, 4, 0, 0);
    tv[18] = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  6, 5, 0, 0);
    tv[19] = mk(1, 0,  0, 0, 0, 0,  1, 0, 1,  6, 0, 1, 0);
    tv[20] = mk(0, 0,  0, 0, 0, 0,  1, 0, 0,  6, 0, 0, 0); // run low

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
`ifdef PWM_ONESHOT_EN
    oneshot = 1'b0;
`endif
    #22;
    check("reset_state", {27'd0, obs()}, {27'd0, pk(1, 0, 0, 0, 0, 0, 0)});
    rst_n = 1'b1;
    #10;

    for (int i = 0; i < 21; i++) begin
      drive(tv[i].run, tv[i].vld, tv[i].per, tv[i].fn, tv[i].c1, tv[i].ps);
      step();
      check($sformatf("vec%0d", i), {27'd0, obs()},
            {27'd0, pk(tv[i].e_rdy, tv[i].e_err, tv[i].e_en, tv[i].e_per, tv[i].e_cnt,
                       tv[i].e_pe, tv[i].e_cd)});
    end
    check("active_func_c1_c2", {30'd0, functions, compare1, compare2}, {30'd0, 2'd1, 16'd2, 16'd3});

    // Prescale 2, period 3: a count every 3 clk and a period_end every 9 clk.
    drive(0, 1, 3, 0, 1, 2); step();
    drive(0, 0, 0, 0, 0, 0); step();
    check("presc_commit", {48'd0, period}, 64'd3);
    drive(1, 0, 0, 0, 0, 0); step();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) step();
      check($sformatf("presc_k%0d", k), {47'd0, count_val, period_end},
            {47'd0, 16'((k / 3) % 3), 1'((k > 0) && (k % 9 == 0))});
    end

    // Reserved functions code is rejected.
    drive(1, 1, 9, 3, 7, 0); step();
    check("err_pulse", {45'd0, cfg_err, cfg_ready, functions, period},
          {45'd0, 1'b1, 1'b1, 2'd0, 16'd3});
    drive(1, 0, 0, 0, 0, 0); step();
    check("err_clear", {62'd0, cfg_err, cfg_ready}, {62'd0, 1'b0, 1'b1});

    // Write on the same edge as a wrap: commit waits for the following wrap.
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 4, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    check("sim_start", {27'd0, obs()}, {27'd0, pk(1, 0, 1, 4, 0, 0, 0)});
    step(); step(); step();
    check("sim_cnt3", {48'd0, count_val}, 64'd3);
    drive(1, 1, 5, 0, 1, 0); step();
    check("sim_wrap_accept", {27'd0, obs()}, {27'd0, pk(0, 0, 1, 4, 0, 1, 0)});
    drive(1, 0, 0, 0, 0, 0);
    step(); step(); step();
    check("sim_hold_cnt3", {27'd0, obs()}, {27'd0, pk(0, 0, 1, 4, 3, 0, 0)});
    step();
    check("sim_commit", {27'd0, obs()}, {27'd0, pk(0, 0, 1, 5, 0, 1, 1)});
    step();
    check("sim_ready", {27'd0, obs()}, {27'd0, pk(1, 0, 1, 5, 1, 0, 0)});

    // Asynchronous reset while a commit is pending.
    drive(1, 1, 7, 0, 1, 0); step();
    check("pend_entered", {63'd0, cfg_ready}, 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {27'd0, obs()}, {27'd0, pk(1, 0, 0, 0, 0, 0, 0)});
    check("async_reset_regs", {30'd0, functions, compare1, compare2}, 64'd0);
    #4 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("shadow_lost%0d", k), {47'd0, period, commit_done}, 64'd0);
    end

`ifdef PWM_ONESHOT_EN
    oneshot = 1'b1;
    drive(0, 1, 3, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    check("os_start", {27'd0, obs()}, {27'd0, pk(1, 0, 1, 3, 0, 0, 0)});
    step(); step(); step();
    check("os_wrap", {27'd0, obs()}, {27'd0, pk(1, 0, 1, 3, 0, 1, 0)});
    step();
    check("os_stop", {63'd0, pwm_en}, 64'd0);
    step();
    check("os_hold", {63'd0, pwm_en}, 64'd0);
    drive(0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    check("os_rearm", {63'd0, pwm_en}, 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
